// File: rtl/muldiv_hilo_pkg.sv
// Shared op-code encoding, FSM states and divide constants for the mul/div HI/LO unit.
package muldiv_hilo_pkg;

  // Must stay identical to the single-cycle ALU control encoding.
  localparam logic [4:0] ALU_MUL   = 5'b01001;
  localparam logic [4:0] ALU_DIV   = 5'b01010;
  localparam logic [4:0] ALU_DIVU  = 5'b01101;
  localparam logic [4:0] ALU_MULTU = 5'b01110;

  localparam int unsigned DIV_ITERS = 32;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StFix
  } state_e;

  function automatic logic is_mul_op(input logic [4:0] ctrl);
    return (ctrl == ALU_MUL) || (ctrl == ALU_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [4:0] ctrl);
    return (ctrl == ALU_DIV) || (ctrl == ALU_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [4:0] ctrl);
    return (ctrl == ALU_MUL) || (ctrl == ALU_DIV);
  endfunction

endpackage

// File: rtl/muldiv_hilo_div_step.sv
// One combinational restoring-division step: shift a dividend bit into the remainder,
// subtract the divisor when it fits and shift the resulting quotient bit in.
module div_step (
  input  logic [31:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] rem_o,
  output logic [31:0] quo_o
);

  logic [32:0] trial;
  logic        fit;

  always_comb begin
    trial = {rem_i, quo_i[31]};
    fit   = trial >= {1'b0, divisor_i};
    // When fit, the true difference is below the divisor, so the low 32 bits are exact.
    rem_o = fit ? (trial[31:0] - divisor_i) : trial[31:0];
    quo_o = {quo_i[30:0], fit};
  end

endmodule

// File: rtl/muldiv_hilo.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers and mthi/mtlo writes.
module muldiv_hilo #(
  parameter int unsigned MUL_LAT   = 3,
  parameter int unsigned DIV_ITERS = muldiv_hilo_pkg::DIV_ITERS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  aluCtrl,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  input  logic        mthi_we,
  input  logic        mtlo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] highresult,
  output logic [31:0] lowresult
);

  import muldiv_hilo_pkg::*;

  localparam int unsigned CntMax = (MUL_LAT > DIV_ITERS) ? MUL_LAT : DIV_ITERS;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic            a_neg_q, a_neg_d;
  logic            b_neg_q, b_neg_d;
  logic [31:0]     quo_q, quo_d;
  logic [31:0]     rem_q, rem_d;
  logic [31:0]     dvs_q, dvs_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic            done_q, done_d;
  logic            div_zero_q, div_zero_d;

  logic            accept;
  logic            op_signed;
  logic [31:0]     step_rem, step_quo;
  logic [63:0]     op_a_ext, op_b_ext, product;
  logic [31:0]     quo_fix, rem_fix;

  div_step u_div_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  always_comb begin
    op_signed = is_signed_op(aluCtrl);
    accept    = (state_q == StIdle) && start && (is_mul_op(aluCtrl) || is_div_op(aluCtrl));
    // Sign flags are only set for signed ops, so they double as extension bits for multu.
    op_a_ext  = {{32{a_neg_q}}, a_q};
    op_b_ext  = {{32{b_neg_q}}, b_q};
    product   = op_a_ext * op_b_ext;
    quo_fix   = (a_neg_q ^ b_neg_q) ? -quo_q : quo_q;
    rem_fix   = a_neg_q ? -rem_q : rem_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    a_neg_d    = a_neg_q;
    b_neg_d    = b_neg_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept) begin
          a_d     = operandA;
          b_d     = operandB;
          a_neg_d = op_signed & operandA[31];
          b_neg_d = op_signed & operandB[31];
          quo_d   = (op_signed & operandA[31]) ? -operandA : operandA;
          dvs_d   = (op_signed & operandB[31]) ? -operandB : operandB;
          rem_d   = '0;
          if (is_mul_op(aluCtrl)) begin
            state_d = StMul;
            cnt_d   = CntW'(MUL_LAT - 1);
          end else begin
            state_d = StDiv;
            cnt_d   = CntW'(DIV_ITERS - 1);
          end
        end else begin
          if (mthi_we) hi_d = wdata;
          if (mtlo_we) lo_d = wdata;
        end
      end
      StMul: begin
        if (cnt_q == '0) begin
          hi_d    = product[63:32];
          lo_d    = product[31:0];
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDiv: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == '0) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StFix: begin
        if (b_q == '0) begin
          // Divide by zero reports the raw dividend, not the sign-corrected remainder.
          lo_d       = '1;
          hi_d       = a_q;
          div_zero_d = 1'b1;
        end else begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      a_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
      quo_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      a_neg_q    <= a_neg_d;
      b_neg_q    <= b_neg_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign done       = done_q;
  assign div_zero   = div_zero_q;
  assign highresult = hi_q;
  assign lowresult  = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed self-checking bench for muldiv_hilo with hand-computed HI/LO results.
module tb_muldiv_hilo;

  localparam logic [4:0] OpMul   = 5'b01001;
  localparam logic [4:0] OpDiv   = 5'b01010;
  localparam logic [4:0] OpDivu  = 5'b01101;
  localparam logic [4:0] OpMultu = 5'b01110;

  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  aluCtrl;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic        mthi_we;
  logic        mtlo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] highresult;
  logic [31:0] lowresult;

  int n_checks;
  int n_errors;

  muldiv_hilo #(
    .MUL_LAT   (3),
    .DIV_ITERS (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .aluCtrl    (aluCtrl),
    .operandA   (operandA),
    .operandB   (operandB),
    .mthi_we    (mthi_we),
    .mtlo_we    (mtlo_we),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .highresult (highresult),
    .lowresult  (lowresult)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done should be high.
  // poke_at > 0 re-pulses start (other operands) and mthi_we on that busy cycle.
  task automatic run_op(input string tag, input logic [4:0] ctrl, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cycles, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_dz, input int poke_at);
    int cycles;
    start    = 1'b1;
    aluCtrl  = ctrl;
    operandA = a;
    operandB = b;
    @(negedge clk);
    start  = 1'b0;
    check_eq({tag, "_done_low"}, {31'b0, done}, 32'd0);
    cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      if (cycles == poke_at) begin
        start    = 1'b1;
        aluCtrl  = OpMul;
        operandA = 32'd3;
        operandB = 32'd4;
        mthi_we  = 1'b1;
        wdata    = 32'h0000_DEAD;
      end else begin
        start   = 1'b0;
        mthi_we = 1'b0;
      end
      @(negedge clk);
    end
    start   = 1'b0;
    mthi_we = 1'b0;
    check_eq({tag, "_busy_cycles"}, cycles, exp_cycles);
    check_eq({tag, "_done"}, {31'b0, done}, 32'd1);
    check_eq({tag, "_hi"}, highresult, exp_hi);
    check_eq({tag, "_lo"}, lowresult, exp_lo);
    check_eq({tag, "_div_zero"}, {31'b0, div_zero}, {31'b0, exp_dz});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    start    = 1'b0;
    aluCtrl  = '0;
    operandA = '0;
    operandB = '0;
    mthi_we  = 1'b0;
    mtlo_we  = 1'b0;
    wdata    = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_done", {31'b0, done}, 32'd0);
    check_eq("rst_dz", {31'b0, div_zero}, 32'd0);
    check_eq("rst_hi", highresult, 32'd0);
    check_eq("rst_lo", lowresult, 32'd0);

    run_op("mul", OpMul, 32'hFFFF_FFFE, 32'd3, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 0);
    // Back-to-back: start again in the done cycle.
    run_op("multu", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 32'hFFFF_FFFE, 32'h0000_0001,
           1'b0, 0);
    @(negedge clk);
    check_eq("done_pulse", {31'b0, done}, 32'd0);

    run_op("div_m7_2", OpDiv, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
    run_op("div_7_m2", OpDiv, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD, 1'b0, 0);
    run_op("divu_100_7", OpDivu, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0, 0);
    run_op("divu_5_0", OpDivu, 32'd5, 32'd0, 33, 32'd5, 32'hFFFF_FFFF, 1'b1, 0);
    run_op("div_m7_0", OpDiv, 32'hFFFF_FFF9, 32'd0, 33, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 0);
    run_op("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000, 1'b0, 0);
    // Mid-divide start and mthi both ignored while busy.
    run_op("div_poke", OpDivu, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0, 10);
    @(negedge clk);

    // Invalid code is ignored.
    start   = 1'b1;
    aluCtrl = 5'b00000;
    @(negedge clk);
    start = 1'b0;
    check_eq("bad_op_busy", {31'b0, busy}, 32'd0);
    check_eq("bad_op_hi", highresult, 32'd2);

    mtlo_we = 1'b1;
    wdata   = 32'h0000_1234;
    @(negedge clk);
    mtlo_we = 1'b0;
    check_eq("mtlo_lo", lowresult, 32'h0000_1234);
    check_eq("mtlo_hi", highresult, 32'd2);

    mthi_we = 1'b1;
    mtlo_we = 1'b1;
    wdata   = 32'hCAFE_F00D;
    @(negedge clk);
    mthi_we = 1'b0;
    mtlo_we = 1'b0;
    check_eq("mthilo_hi", highresult, 32'hCAFE_F00D);
    check_eq("mthilo_lo", lowresult, 32'hCAFE_F00D);

    // Start wins over a simultaneous mtlo.
    mtlo_we = 1'b1;
    wdata   = 32'h5555_5555;
    run_op("mul_vs_mtlo", OpMultu, 32'd6, 32'd7, 3, 32'd0, 32'd42, 1'b0, 0);
    mtlo_we = 1'b0;
    @(negedge clk);

    // Reset during divide iteration 10.
    start    = 1'b1;
    aluCtrl  = OpDivu;
    operandA = 32'd1000;
    operandB = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check_eq("pre_rst_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_rst_busy", {31'b0, busy}, 32'd0);
    check_eq("mid_rst_hi", highresult, 32'd0);
    check_eq("mid_rst_lo", lowresult, 32'd0);
    check_eq("mid_rst_done", {31'b0, done}, 32'd0);
    repeat (30) begin
      @(negedge clk);
      if (done) check_eq("mid_rst_late_done", {31'b0, done}, 32'd0);
    end
    check_eq("mid_rst_final_lo", lowresult, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
